shift_ser_tx: RTL and testbench
===============================

SHIFT_SER_TX -- requirements
Module: shift_ser_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data bits per frame (legal values 2..16).
REQ-002 The block SHALL have parameter DIV, default 2, giving the clock cycles per serial bit (legal values 1..255).
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on posedge clk.
REQ-004 Port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port din, input, WIDTH bits: parallel word to transmit.
REQ-006 Port dir, input, 1 bit: bit order; 0 = LSB first, 1 = MSB first.
REQ-007 Port load_valid, input, 1 bit: din/dir present and valid.
REQ-008 Port load_ready, output, 1 bit: block can accept a word.
REQ-009 Port sout, output, 1 bit: serial line; idles high.
REQ-010 Port busy, output, 1 bit: high while a frame is in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 The frame format SHALL be: start bit (0), then WIDTH data bits, then stop bit (1); each bit SHALL be held exactly DIV cycles.
REQ-013 The state machine SHALL have states IDLE, START, DATA and STOP; IDLE->START on handshake; START->DATA after DIV cycles; DATA->STOP after WIDTH*DIV cycles; STOP->IDLE after DIV cycles.
REQ-014 Handshake: a word SHALL be accepted on a posedge where load_valid=1 and load_ready=1.
REQ-015 load_ready SHALL be 1 only in IDLE and SHALL be driven combinationally from state.
REQ-016 On acceptance, din and dir SHALL be captured into an internal WIDTH-bit shift register and direction flag; later changes to din/dir SHALL have no effect on the current frame.
REQ-017 sout SHALL be registered; the start bit SHALL appear on the same edge as acceptance (visible in the cycle after the handshake cycle).
REQ-018 In DATA with dir=0, sout SHALL equal shreg[0] and the register SHALL shift toward bit 0 once every DIV cycles; with dir=1, sout SHALL equal shreg[WIDTH-1] and the register SHALL shift toward the MSB.
REQ-019 A bit-period counter SHALL count 0..DIV-1 and wrap; a bit counter SHALL count 0..WIDTH-1 in DATA; both SHALL be cleared on every state change.
REQ-020 done SHALL be 1 for exactly one cycle, during the last cycle of STOP.
REQ-021 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-022 load_valid asserted outside IDLE SHALL be ignored, with no capture and no effect on the frame.
REQ-023 The minimum gap between frames SHALL be one IDLE cycle; a frame SHALL span (WIDTH+2)*DIV cycles.
REQ-024 With DIV=1, every bit SHALL last one cycle and all rules above SHALL still hold.
REQ-025 load_valid held continuously SHALL start a new frame on each IDLE cycle.

Reset
REQ-026 While clr=0: state=IDLE, sout=1, busy=0, done=0, load_ready=1 (once clr=1), shift register=0, counters=0.
REQ-027 Assertion of clr mid-frame SHALL abort the frame immediately (asynchronously); sout SHALL go to 1 and no done pulse SHALL be issued.
REQ-028 The first handshake SHALL be accepted on the first posedge after clr is released.

Verification
REQ-029 WIDTH=4, DIV=2, din=4'b1011, dir=0, one-cycle load_valid -> sout = 0,1,1,0,1,1, each for 2 cycles; done pulses in cycle 12 after the handshake; busy is high for 12 cycles.
REQ-030 Same din with dir=1 -> sout = 0,1,0,1,1,1, each for 2 cycles.
REQ-031 Change din to 4'b0000 one cycle after the handshake (din=4'b1011) -> transmitted data bits still 1,1,0,1 (LSB first).
REQ-032 Pulse load_valid with din=4'b0110 during DATA -> ignored; the original frame completes unchanged and no second frame starts.
REQ-033 Assert clr during the second data bit -> sout=1, busy=0 and load_ready=1 immediately; no done pulse.
REQ-034 DIV=1, load_valid held high with din=4'b1111 -> back-to-back 6-cycle frames separated by exactly one idle cycle (sout=1), with one done pulse per frame.

Source files
------------

// File: rtl/shift_ser_tx_if.sv
// Parallel-load / serial-out handshake bundle for shift_ser_tx.
// master drives the word, slave (the transmitter) drives the line and status.
interface shift_ser_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output din, dir, load_valid,
    input  load_ready, sout, busy, done
  );

  modport slave (
    input  din, dir, load_valid,
    output load_ready, sout, busy, done
  );
endinterface

// File: rtl/shift_ser_tx.sv
// Serial transmitter: start(0), WIDTH data bits in selectable order, stop(1),
// every bit held DIV clocks. Word is captured on the load handshake.
module shift_ser_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 2
) (
  input  logic         clk,
  input  logic         clr,
  shift_ser_tx_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [BW-1:0]    r_bit, w_bit_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next, w_shifted;
  logic             r_dir, w_dir_next;
  logic             r_sout, w_sout_next;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CW'(DIV - 1));

  // The outgoing bit always sits at the end of the register selected by r_dir.
  assign w_shifted = r_dir ? {r_shreg[WIDTH-2:0], 1'b0}
                           : {1'b0, r_shreg[WIDTH-1:1]};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shreg_next = r_shreg;
    w_dir_next   = r_dir;
    w_sout_next  = r_sout;
    case (r_state)
      IDLE: begin
        w_cnt_next  = '0;
        w_sout_next = 1'b1;
        if (bus.load_valid) begin
          w_state_next = START;
          w_shreg_next = bus.din;
          w_dir_next   = bus.dir;
          w_sout_next  = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_bit_next   = '0;
          w_sout_next  = r_dir ? r_shreg[WIDTH-1] : r_shreg[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == BW'(WIDTH - 1)) begin
            w_state_next = STOP;
            w_bit_next   = '0;
            w_sout_next  = 1'b1;
          end else begin
            w_shreg_next = w_shifted;
            w_bit_next   = r_bit + 1'b1;
            w_sout_next  = r_dir ? w_shifted[WIDTH-1] : w_shifted[0];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_sout_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_dir   <= 1'b0;
      r_sout  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shreg <= w_shreg_next;
      r_dir   <= w_dir_next;
      r_sout  <= w_sout_next;
    end
  end

  assign bus.load_ready = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == STOP) && w_bit_end;
  assign bus.sout       = r_sout;
endmodule

// File: tb/tb_shift_ser_tx.sv
// Bench for shift_ser_tx: vector table, corner sequences, random frames,
// plus a DIV=1 instance exercising back-to-back frames.
module tb_shift_ser_tx;
  localparam int W = 4;
  localparam int D = 2;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  shift_ser_tx_if #(.WIDTH(W)) bus0 ();
  shift_ser_tx_if #(.WIDTH(W)) bus1 ();

  shift_ser_tx #(.WIDTH(W), .DIV(D)) dut0 (.clk(clk), .clr(clr), .bus(bus0.slave));
  shift_ser_tx #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] din;
    logic         dir;
    logic [W+1:0] seq;   // transmitted line bits, seq[W+1] goes out first
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Frame line content derived straight from the frame format.
  function automatic logic [W+1:0] model_seq(input logic [W-1:0] d, input logic dr);
    logic [W+1:0] s;
    s[W+1] = 1'b0;
    s[0]   = 1'b1;
    for (int i = 0; i < W; i++) s[W-i] = dr ? d[W-1-i] : d[i];
    return s;
  endfunction

  // Called at a negedge with dut0 idle. mode 1: din/dir change after handshake;
  // mode 2: spurious load pulse during DATA.
  task automatic send(input logic [W-1:0] d, input logic dr, input logic [W+1:0] seq, input int mode);
    int span;
    span = (W + 2) * D;
    chk("ready_before_load", bus0.load_ready, 1);
    bus0.din = d;
    bus0.dir = dr;
    bus0.load_valid = 1'b1;
    @(negedge clk);
    bus0.load_valid = 1'b0;
    for (int k = 1; k <= span; k++) begin
      if (mode == 1 && k == 1) begin
        bus0.din = '0;
        bus0.dir = ~dr;
      end
      if (mode == 2 && k == D + 2) begin
        bus0.din = 4'b0110;
        bus0.dir = ~dr;
        bus0.load_valid = 1'b1;
      end
      if (mode == 2 && k == D + 3) bus0.load_valid = 1'b0;
      chk("sout", bus0.sout, seq[W+1-((k-1)/D)]);
      chk("busy", bus0.busy, 1);
      chk("done", bus0.done, (k == span));
      chk("ready_in_frame", bus0.load_ready, 0);
      @(negedge clk);
    end
    chk("idle_sout", bus0.sout, 1);
    chk("idle_busy", bus0.busy, 0);
    chk("idle_done", bus0.done, 0);
    $display("frame din=%b dir=%0d mode=%0d expected_line=%b", d, dr, mode, seq);
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{4'b1011, 1'b0, 6'b011011};
    tbl[1] = '{4'b1011, 1'b1, 6'b010111};
    tbl[2] = '{4'b0001, 1'b1, 6'b000011};
    tbl[3] = '{4'b1000, 1'b0, 6'b000011};
    tbl[4] = '{4'b1100, 1'b0, 6'b000111};
    tbl[5] = '{4'b0110, 1'b1, 6'b001101};
    tbl[6] = '{4'b1111, 1'b0, 6'b011111};
    tbl[7] = '{4'b0000, 1'b1, 6'b000001};

    clr = 1'b0;
    bus0.din = '0; bus0.dir = 1'b0; bus0.load_valid = 1'b0;
    bus1.din = '0; bus1.dir = 1'b0; bus1.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sout", bus0.sout, 1);
    chk("reset_busy", bus0.busy, 0);
    chk("reset_done", bus0.done, 0);
    chk("reset_sout_div1", bus1.sout, 1);
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus0.load_ready, 1);
    $display("reset released");

    // Table frames back to back: each begins after exactly one idle cycle.
    for (int i = 0; i < 8; i++) send(tbl[i].din, tbl[i].dir, tbl[i].seq, 0);

    send(4'b1011, 1'b0, 6'b011011, 1);
    send(4'b1011, 1'b0, 6'b011011, 2);
    for (int i = 0; i < 4; i++) begin
      chk("no_second_frame", bus0.busy, 0);
      @(negedge clk);
    end

    // Abort during the second data bit (din=1001 LSB first: second bit is 0).
    bus0.din = 4'b1001; bus0.dir = 1'b0; bus0.load_valid = 1'b1;
    @(negedge clk);
    bus0.load_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_sout", bus0.sout, 0);
    #2 clr = 1'b0;
    #1;
    chk("abort_sout", bus0.sout, 1);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_ready", bus0.load_ready, 1);
    chk("abort_done", bus0.done, 0);
    @(negedge clk);
    chk("abort_hold_sout", bus0.sout, 1);
    chk("abort_hold_done", bus0.done, 0);
    $display("mid-frame reset applied");
    clr = 1'b1;
    send(4'b1011, 1'b0, 6'b011011, 0);

    // DIV=1 with load_valid held: 6-cycle frames with one idle cycle between.
    chk("div1_idle", bus1.busy, 0);
    bus1.din = 4'b1111; bus1.dir = 1'b0; bus1.load_valid = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 21; k++) begin
      int pos;
      @(negedge clk);
      pos = (k - 1) % 7;
      if (bus1.done === 1'b1) done_cnt++;
      chk("div1_sout", bus1.sout, (pos < 6) ? ((pos == 0) ? 0 : 1) : 1);
      chk("div1_busy", bus1.busy, (pos < 6));
      chk("div1_done", bus1.done, (pos == 5));
      chk("div1_ready", bus1.load_ready, (pos == 6));
    end
    bus1.load_valid = 1'b0;
    chk("div1_done_count", done_cnt, 3);
    $display("div1 streaming: %0d done pulses", done_cnt);

    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] d;
      logic         dr;
      int           gap;
      d   = W'($urandom_range(0, 15));
      dr  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        chk("gap_busy", bus0.busy, 0);
        @(negedge clk);
      end
      send(d, dr, model_seq(d, dr), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
